// File: rtl/sdram_phy_lite.sv
// Lite SDRAM PHY: registered command/write-data pads, read-beat tracking and capture.
// Optional read FIFO is enabled by defining SDRAM_PHY_RD_FIFO_EN.
module sdram_phy_lite #(
    parameter int unsigned CHIP_NUM   = 2,
    parameter int unsigned CHIP_DW    = 16,
    parameter int unsigned CAS_LAT    = 2,
    parameter int unsigned BURST_LEN  = 1,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned DW        = CHIP_NUM * CHIP_DW,
    localparam int unsigned NB        = DW / 8
) (
    input  logic          axi_clk,
    input  logic          axi_rstn,
    input  logic          ctl_sel_n,
    input  logic          ctl_ras_n,
    input  logic          ctl_cas_n,
    input  logic          ctl_we_n,
    input  logic          ctl_cke,
    input  logic [12:0]   ctl_addr,
    input  logic [1:0]    ctl_bank_addr,
    input  logic [NB-1:0] ctl_dqm,
    input  logic [DW-1:0] ctl_wr_data,
    input  logic [NB-1:0] ctl_dout_valid,
    output logic          sdram_sel_n,
    output logic          sdram_ras_n,
    output logic          sdram_cas_n,
    output logic          sdram_we_n,
    output logic          sdram_cke,
    output logic [12:0]   sdram_addr,
    output logic [1:0]    sdram_bank_addr,
    output logic [NB-1:0] sdram_dqm,
    output logic [DW-1:0] sdram_dq_o,
    output logic [NB-1:0] sdram_dq_oe,
    input  logic [DW-1:0] sdram_dq_i,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_ovf,
    input  logic          ovf_clr
);

    localparam int unsigned CW = $clog2(BURST_LEN + 1);

    logic          cmd_read_c;
    logic          cmd_stop_c;
    logic          beat_c;
    logic [CW-1:0] burst_cnt;
    logic [CAS_LAT:0] beat_sr;
    logic [DW-1:0] cap_data;
    logic          cap_valid;

    // Command decode on the sampled controller pins (active-low encodings).
    assign cmd_read_c = ~ctl_sel_n &  ctl_ras_n & ~ctl_cas_n &  ctl_we_n;
    assign cmd_stop_c = ~ctl_sel_n &  ctl_ras_n & ~ctl_we_n;
    assign beat_c     = (burst_cnt != '0);

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            sdram_sel_n     <= 1'b1;
            sdram_ras_n     <= 1'b1;
            sdram_cas_n     <= 1'b1;
            sdram_we_n      <= 1'b1;
            sdram_cke       <= 1'b0;
            sdram_addr      <= '0;
            sdram_bank_addr <= '0;
            sdram_dqm       <= '0;
            sdram_dq_o      <= '0;
            sdram_dq_oe     <= '0;
        end else begin
            sdram_sel_n     <= ctl_sel_n;
            sdram_ras_n     <= ctl_ras_n;
            sdram_cas_n     <= ctl_cas_n;
            sdram_we_n      <= ctl_we_n;
            sdram_cke       <= ctl_cke;
            sdram_addr      <= ctl_addr;
            sdram_bank_addr <= ctl_bank_addr;
            sdram_dqm       <= ctl_dqm;
            sdram_dq_o      <= ctl_wr_data;
            sdram_dq_oe     <= ctl_dout_valid;
        end
    end

    // Beat counter: the beat of the current cycle is always emitted, even when a
    // new READ reloads the counter, so an interrupting burst never drops a beat.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            burst_cnt <= '0;
            beat_sr   <= '0;
            cap_data  <= '0;
            cap_valid <= 1'b0;
        end else begin
            if (cmd_read_c) begin
                burst_cnt <= CW'(BURST_LEN);
            end else if (cmd_stop_c) begin
                burst_cnt <= '0;
            end else if (beat_c) begin
                burst_cnt <= burst_cnt - CW'(1);
            end
            beat_sr   <= {beat_sr[CAS_LAT-1:0], beat_c};
            cap_valid <= beat_sr[CAS_LAT];
            if (beat_sr[CAS_LAT]) begin
                cap_data <= sdram_dq_i;
            end
        end
    end

`ifdef SDRAM_PHY_RD_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          pop_c;
    logic          full_c;
    logic          push_c;
    logic          drop_c;
    logic [AW:0]   count_next_c;
    logic [AW:0]   after_pop_c;
    logic [AW-1:0] rptr_next_c;

    assign pop_c        = rd_valid & rd_ready;
    assign full_c       = (count == (AW+1)'(FIFO_DEPTH));
    assign push_c       = cap_valid & (~full_c | pop_c);
    assign drop_c       = cap_valid & full_c & ~pop_c;
    assign after_pop_c  = count - (AW+1)'(pop_c);
    assign count_next_c = after_pop_c + (AW+1)'(push_c);
    assign rptr_next_c  = rptr + AW'(pop_c);

    always_ff @(posedge axi_clk) begin
        if (push_c) begin
            mem[wptr] <= cap_data;
        end
    end

    // rd_data mirrors the head entry; it keeps the last popped value when empty.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            if (push_c) begin
                wptr <= wptr + AW'(1);
            end
            rptr     <= rptr_next_c;
            count    <= count_next_c;
            rd_valid <= (count_next_c != '0);
            if (after_pop_c == '0) begin
                if (push_c) begin
                    rd_data <= cap_data;
                end
            end else begin
                rd_data <= mem[rptr_next_c];
            end
            if (drop_c) begin
                rd_ovf <= 1'b1;
            end else if (ovf_clr) begin
                rd_ovf <= 1'b0;
            end
        end
    end
`else
    logic unused_rd_ctl;

    assign unused_rd_ctl = ^{rd_ready, ovf_clr, FIFO_DEPTH[0]};
    assign rd_data       = cap_data;
    assign rd_valid      = cap_valid;
    assign rd_ovf        = 1'b0;
`endif

endmodule
